urx_cmd_ctrl: RTL and testbench
===============================

# urx_cmd_ctrl

Frame-level controller behind the UART receive PHY. Consumes `rx_data`/`rx_vld` byte strobes and assembles 5-byte command frames: header, address, data high, data low, checksum. Validates the checksum, enforces an inter-byte timeout on the 1 µs tick, and issues one register-write request per good frame to the register bank over a req/ack handshake. Sits in `commu_top` between `phy_urx` and the register file.

## Interface
- `HDR`, 8'hA5, frame header byte
- `TOUT_US`, 16'd1000, inter-byte timeout in µs (legal range 2..65535)

- `clk_sys`  in  1  system clock, 100 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `pluse_us`  in  1  one-cycle strobe every 1 µs
- `rx_data`  in  8  received byte, valid with `rx_vld`
- `rx_vld`  in  1  one-cycle byte strobe from the PHY
- `cmd_addr`  out  8  write address; reset 8'h00
- `cmd_data`  out  16  write data, {DH,DL}; reset 16'h0000
- `cmd_wr`  out  1  write request, level; reset 0
- `cmd_ack`  in  1  write accepted by the register bank
- `err_sum`  out  1  one-cycle pulse, checksum mismatch; reset 0
- `err_tout`  out  1  one-cycle pulse, frame timeout; reset 0
- `err_cnt`  out  8  total errors, saturates at 8'hFF; reset 0
- `busy`  out  1  high in any state other than IDLE; reset 0

## Operation
- States: IDLE, ADDR, DH, DL, SUM, ISSUE. Reset state is IDLE.
- IDLE: on `rx_vld` with `rx_data==HDR`, go to ADDR. Any other byte is dropped silently.
- ADDR, DH, DL: each `rx_vld` captures the byte into the shadow addr, data-high or data-low register and advances to the next state. A byte equal to HDR is treated as ordinary data here.
- SUM: on `rx_vld`, compare `rx_data` with (addr+DH+DL) mod 256, computed in an 8-bit wrap-around add.
  - Match: load `cmd_addr`/`cmd_data` from the shadow registers, go to ISSUE.
  - Mismatch: pulse `err_sum`, increment `err_cnt`, go to IDLE.
- ISSUE: hold `cmd_wr`=1 with `cmd_addr`/`cmd_data` stable. When `cmd_ack` is sampled high, clear `cmd_wr` and go to IDLE.
  - `rx_vld` in ISSUE is an overrun: the byte is dropped and `err_cnt` increments (no pulse output).
- Timeout, active in ADDR..SUM only:
  - A 16-bit µs counter clears on entry to ADDR and on every accepted byte, and increments on `pluse_us`.
  - When it reaches `TOUT_US`: pulse `err_tout`, increment `err_cnt`, go to IDLE. The partial frame is discarded.
- Simultaneous events:
  - `rx_vld` and timeout expiry in the same cycle: the byte wins, counter clears, no error.
  - Two error increments in one cycle are impossible by construction.
  - `err_cnt` holds at 8'hFF.
- Reset mid-frame or mid-ISSUE: all outputs return to reset values immediately (async). A pending write is abandoned and never re-issued.

## Timing
- `cmd_wr` rises on the clock edge that samples the SUM byte's `rx_vld`, i.e. it is visible in the cycle after the strobe.
- `cmd_ack` high in the first `cmd_wr` cycle gives a 1-cycle request; `cmd_wr` is low on the following cycle and the state is IDLE.
- A new HDR byte is acceptable the cycle after leaving ISSUE.
- `err_sum`/`err_tout` are registered, exactly 1 cycle wide, asserted the cycle after the triggering event. `err_cnt` updates on the same edge.
- Timeout resolution is ±1 µs: expiry occurs on the `TOUT_US`-th `pluse_us` after the last accepted byte.
- Byte rate is at most 1 per 86.8 µs at 115200 baud, so no back-to-back `rx_vld` occurs in practice. The design must nevertheless accept `rx_vld` on consecutive cycles.

## Structure
- Shared package `commu_pkg`: state encoding (3-bit localparams), the default `HDR`, frame length 5, and the `TOUT_US` default.
- One natural sub-module: `urx_tout_cnt`. It is the µs timeout counter, with inputs clear/enable/`pluse_us` and output `expire`.
- FSM, shadow registers, checksum adder and error counter stay in the top module.

## Test plan
- Frame A5 12 34 56 9C → `cmd_wr`=1, `cmd_addr`=8'h12, `cmd_data`=16'h3456. Holding `cmd_ack` low for 10 cycles keeps `cmd_wr` and the data stable. `cmd_ack` then drops `cmd_wr` next cycle, `err_cnt`=0.
- Frame A5 12 34 56 9D → no `cmd_wr`, one `err_sum` pulse, `err_cnt`=1, `busy`=0 afterwards.
- A5 12, then silence for 1000 `pluse_us` → `err_tout` pulse, `err_cnt`=1. A following good frame A5 01 00 01 02 issues `cmd_addr`=01, `cmd_data`=0001.
- Stray bytes 00 FF 5A before A5 FF FF FF FD → ignored without error. Frame issues addr FF, data FFFF; the checksum wraps to FD.
- During ISSUE (ack withheld), inject `rx_vld` with 8'hA5 → byte dropped, `err_cnt`=1, `cmd_addr`/`cmd_data` unchanged.
- Force 300 checksum errors → `err_cnt` saturates at 8'hFF. Assert `rst_n` low mid-frame at A5 12 → all outputs zero, FSM in IDLE, and the next frame decodes correctly.

Source files
------------

// File: rtl/commu_pkg.sv
// Shared definitions for the UART command path: frame constants, FSM state
// encoding and the frame checksum helper.
package commu_pkg;

  localparam logic [7:0]  HDR_DEFAULT     = 8'hA5;
  localparam int          FRAME_LEN       = 5;
  localparam logic [15:0] TOUT_US_DEFAULT = 16'd1000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DH    = 3'd2;
  localparam logic [2:0] ST_DL    = 3'd3;
  localparam logic [2:0] ST_SUM   = 3'd4;
  localparam logic [2:0] ST_ISSUE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ADDR  = ST_ADDR,
    S_DH    = ST_DH,
    S_DL    = ST_DL,
    S_SUM   = ST_SUM,
    S_ISSUE = ST_ISSUE
  } state_e;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return a + b + c;
  endfunction

endpackage

// File: rtl/urx_tout_cnt.sv
// Inter-byte timeout counter: counts pluse_us strobes while enabled and flags
// expiry combinationally on the strobe that would make the count reach TOUT_US.
module urx_tout_cnt
  import commu_pkg::*;
#(
  parameter logic [15:0] TOUT_US = TOUT_US_DEFAULT
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_pluse_us,
  output logic o_expire
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_en && i_pluse_us) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Flagging one strobe early lets the FSM register err_tout on that same edge.
  assign o_expire = i_en && i_pluse_us && (r_cnt == TOUT_US - 16'd1);

endmodule

// File: rtl/urx_cmd_ctrl.sv
// Assembles 5-byte UART command frames (HDR, addr, DH, DL, sum), checks the
// checksum and inter-byte timeout, and issues one req/ack register write per good frame.
module urx_cmd_ctrl
  import commu_pkg::*;
#(
  parameter logic [7:0]  HDR     = HDR_DEFAULT,
  parameter logic [15:0] TOUT_US = TOUT_US_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_wr,
  input  logic        cmd_ack,
  output logic        err_sum,
  output logic        err_tout,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_addr_sh;
  logic [7:0] r_dh_sh;
  logic [7:0] r_dl_sh;

  logic w_active;
  logic w_expire;
  logic w_cap_addr;
  logic w_cap_dh;
  logic w_cap_dl;
  logic w_load_cmd;
  logic w_err_sum;
  logic w_err_tout;
  logic w_err_ovr;
  logic w_inc_err;

  assign w_active = (r_state == S_ADDR) || (r_state == S_DH) ||
                    (r_state == S_DL)   || (r_state == S_SUM);

  urx_tout_cnt #(.TOUT_US(TOUT_US)) u_tout_cnt (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .i_clr      (rx_vld || !w_active),
    .i_en       (w_active),
    .i_pluse_us (pluse_us),
    .o_expire   (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cap_addr  = 1'b0;
    w_cap_dh    = 1'b0;
    w_cap_dl    = 1'b0;
    w_load_cmd  = 1'b0;
    w_err_sum   = 1'b0;
    w_err_tout  = 1'b0;
    w_err_ovr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_vld && rx_data == HDR) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (rx_vld) begin
          w_cap_addr  = 1'b1;
          w_state_nxt = S_DH;
        end
      end
      S_DH: begin
        if (rx_vld) begin
          w_cap_dh    = 1'b1;
          w_state_nxt = S_DL;
        end
      end
      S_DL: begin
        if (rx_vld) begin
          w_cap_dl    = 1'b1;
          w_state_nxt = S_SUM;
        end
      end
      S_SUM: begin
        if (rx_vld) begin
          if (rx_data == sum8(r_addr_sh, r_dh_sh, r_dl_sh)) begin
            w_load_cmd  = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_err_sum   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        w_err_ovr = rx_vld;
        if (cmd_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A byte arriving with the expiring strobe keeps the frame alive.
    if (w_active && w_expire && !rx_vld) begin
      w_err_tout  = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  assign w_inc_err = w_err_sum || w_err_tout || w_err_ovr;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr_sh <= 8'h00;
      r_dh_sh   <= 8'h00;
      r_dl_sh   <= 8'h00;
      cmd_addr  <= 8'h00;
      cmd_data  <= 16'h0000;
      err_sum   <= 1'b0;
      err_tout  <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      err_sum  <= w_err_sum;
      err_tout <= w_err_tout;
      if (w_cap_addr) r_addr_sh <= rx_data;
      if (w_cap_dh)   r_dh_sh   <= rx_data;
      if (w_cap_dl)   r_dl_sh   <= rx_data;
      if (w_load_cmd) begin
        cmd_addr <= r_addr_sh;
        cmd_data <= {r_dh_sh, r_dl_sh};
      end
      if (w_inc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign cmd_wr = (r_state == S_ISSUE);
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_urx_cmd_ctrl.sv
// Directed self-checking bench for urx_cmd_ctrl: frame decode, checksum,
// timeout, overrun, saturation and asynchronous reset.
module tb_urx_cmd_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        pluse_us = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_wr;
  logic        cmd_ack = 1'b0;
  logic        err_sum;
  logic        err_tout;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  urx_cmd_ctrl dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .rx_data  (rx_data),
    .rx_vld   (rx_vld),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .cmd_wr   (cmd_wr),
    .cmd_ack  (cmd_ack),
    .err_sum  (err_sum),
    .err_tout (err_tout),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input bit gap);
    send(b0); if (gap) tick();
    send(b1); if (gap) tick();
    send(b2); if (gap) tick();
    send(b3); if (gap) tick();
    send(b4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic ack_one();
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      pluse_us = 1'b1;
      tick();
      pluse_us = 1'b0;
      tick();
    end
  endtask

  initial begin
    // Reset values
    tick();
    check("rst_cmd_wr", cmd_wr, 0);
    check("rst_cmd_addr", cmd_addr, 8'h00);
    check("rst_cmd_data", cmd_data, 16'h0000);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Good frame, ack withheld 10 cycles
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C, 1'b1);
    check("a_cmd_wr", cmd_wr, 1);
    check("a_cmd_addr", cmd_addr, 8'h12);
    check("a_cmd_data", cmd_data, 16'h3456);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("a_hold_wr", cmd_wr, 1);
      check("a_hold_dat", {cmd_addr, cmd_data}, 24'h123456);
    end
    ack_one();
    check("a_wr_drop", cmd_wr, 0);
    check("a_busy", busy, 0);
    check("a_err_cnt", err_cnt, 0);

    // Bad checksum
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9D, 1'b0);
    check("b_cmd_wr", cmd_wr, 0);
    check("b_err_sum", err_sum, 1);
    check("b_err_cnt", err_cnt, 1);
    tick();
    check("b_err_sum_1cyc", err_sum, 0);
    check("b_busy", busy, 0);

    // Timeout after 1000 strobes
    do_reset();
    send(8'hA5); send(8'h12);
    pulse_n(999);
    check("c_busy_999", busy, 1);
    check("c_tout_999", err_tout, 0);
    pluse_us = 1'b1;
    tick();
    pluse_us = 1'b0;
    check("c_err_tout", err_tout, 1);
    check("c_err_cnt", err_cnt, 1);
    check("c_busy_idle", busy, 0);
    tick();
    check("c_tout_1cyc", err_tout, 0);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 1'b0);
    check("c2_cmd_wr", cmd_wr, 1);
    check("c2_cmd_addr", cmd_addr, 8'h01);
    check("c2_cmd_data", cmd_data, 16'h0001);
    // Ack in the first request cycle, new header on the next cycle
    ack_one();
    check("c2_wr_1cyc", cmd_wr, 0);
    check("c2_busy", busy, 0);

    // Byte and expiry coincide: byte wins
    send(8'hA5); send(8'h12);
    pulse_n(999);
    pluse_us = 1'b1;
    rx_data  = 8'h34;
    rx_vld   = 1'b1;
    tick();
    pluse_us = 1'b0;
    rx_vld   = 1'b0;
    check("d_no_tout", err_tout, 0);
    check("d_busy", busy, 1);
    check("d_err_cnt", err_cnt, 1);
    send(8'h56); send(8'h9C);
    check("d_cmd", {cmd_wr, cmd_addr, cmd_data}, {1'b1, 24'h123456});
    ack_one();

    // Stray bytes then wrapping checksum
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    check("e_stray_busy", busy, 0);
    check("e_stray_err", err_cnt, 0);
    send_frame(8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 1'b1);
    check("e_cmd_wr", cmd_wr, 1);
    check("e_cmd", {cmd_addr, cmd_data}, 24'hFFFFFF);
    check("e_err_cnt", err_cnt, 0);
    ack_one();

    // Overrun during ISSUE
    do_reset();
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C, 1'b0);
    tick();
    send(8'hA5);
    check("f_err_cnt", err_cnt, 1);
    check("f_no_pulse", {err_sum, err_tout}, 2'b00);
    check("f_cmd_wr", cmd_wr, 1);
    check("f_cmd", {cmd_addr, cmd_data}, 24'h123456);
    ack_one();
    check("f_idle", busy, 0);

    // Async reset mid-ISSUE abandons the write
    send_frame(8'hA5, 8'h21, 8'h43, 8'h65, 8'hC9, 1'b0);
    check("g_cmd_wr", cmd_wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("g_async_wr", cmd_wr, 0);
    check("g_async_cmd", {cmd_addr, cmd_data}, 24'h000000);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("g_no_reissue", cmd_wr, 0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h00, 1'b0);
      if (i == 253) check("h_cnt_254", err_cnt, 8'hFE);
    end
    check("h_sat", err_cnt, 8'hFF);

    // Async reset mid-frame, then clean decode
    send(8'hA5); send(8'h12);
    check("i_busy_mid", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("i_rst_outs", {cmd_wr, err_sum, err_tout, busy, err_cnt, cmd_addr, cmd_data},
          32'h00000000);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 1'b0);
    check("i_cmd", {cmd_wr, cmd_addr, cmd_data}, {1'b1, 24'h010001});
    check("i_err_cnt", err_cnt, 0);
    ack_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
